// File: rtl/vi_pkg.sv
// Shared definitions for the integer ALU writeback stage.
// Contents: opcode constants, XLEN, skid-buffer state encoding, the held-entry
// struct, and a helper that builds an entry from an instruction and its result.
package vi_pkg;

  localparam int XLEN  = 64;
  localparam int REG_W = 5;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  // Only register-register and register-immediate ALU ops write the register
  // file, and never x0. Every other entry still retires, with we low.
  function automatic wb_entry_t make_entry(input logic [6:0]       opcode,
                                           input logic [REG_W-1:0] rd,
                                           input logic [XLEN-1:0]  result);
    wb_entry_t e;
    e.rd   = rd;
    e.data = result;
    e.we   = ((opcode == OP_REG) || (opcode == OP_IMM)) && (rd != '0);
    return e;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Forwarding lookup of one source register against the two held writeback entries.
// Latency: combinational. Backpressure: none, pure lookup.
// Ports: i_head_vld/i_head, i_tail_vld/i_tail held entries; i_rs query; o_hit/o_data result.
module fwd_match
  import vi_pkg::*;
(
  input  logic             i_head_vld,
  input  wb_entry_t        i_head,
  input  logic             i_tail_vld,
  input  wb_entry_t        i_tail,
  input  logic [REG_W-1:0] i_rs,
  output logic             o_hit,
  output logic [XLEN-1:0]  o_data
);

  logic w_head_hit;
  logic w_tail_hit;

  // x0 is hardwired zero, so a query of register 0 never forwards.
  assign w_head_hit = i_head_vld && i_head.we && (i_head.rd == i_rs) && (i_rs != '0);
  assign w_tail_hit = i_tail_vld && i_tail.we && (i_tail.rd == i_rs) && (i_rs != '0);

  assign o_hit  = w_head_hit || w_tail_hit;
  // The tail is the younger write, so it shadows the head.
  assign o_data = w_tail_hit ? i_tail.data :
                  w_head_hit ? i_head.data : '0;

endmodule

// File: rtl/alu_wb_stage.sv
// Two-entry in-order skid buffer between the integer ALU and register writeback.
// Latency: 1 cycle from accept to presentation when empty. Backpressure: ready_o
// drops only when both entries are held; it depends on registered state, not wb_ready_i.
// Ports: clk_i/rsn_i (async active-high reset); valid_i/instr_i/result_i/ready_o input
// side; flush_i; wb_valid_o/wb_ready_i/wb_we_o/wb_rd_o/wb_data_o writeback side;
// fwd_rs{1,2}_i queries with fwd_hit{1,2}_o / fwd_data{1,2}_o answers.
module alu_wb_stage
  import vi_pkg::*;
(
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             valid_i,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  result_i,
  output logic             ready_o,
  input  logic             flush_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic             wb_we_o,
  output logic [REG_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]  wb_data_o,
  input  logic [REG_W-1:0] fwd_rs1_i,
  input  logic [REG_W-1:0] fwd_rs2_i,
  output logic             fwd_hit1_o,
  output logic             fwd_hit2_o,
  output logic [XLEN-1:0]  fwd_data1_o,
  output logic [XLEN-1:0]  fwd_data2_o
);

  wb_state_e r_state;
  wb_entry_t r_head;
  wb_entry_t r_tail;

  logic      w_head_vld;
  logic      w_tail_vld;
  logic      w_push;
  logic      w_pop;
  wb_entry_t w_new;
  logic      w_unused_instr;

  // Upper instruction bits carry operands the writeback stage does not need.
  assign w_unused_instr = ^instr_i[31:12];

  assign w_head_vld = (r_state != ST_EMPTY);
  assign w_tail_vld = (r_state == ST_FULL);

  // Held low for the whole reset window, high straight after release.
  assign ready_o = (r_state != ST_FULL) && !rsn_i;

  assign w_push = valid_i && ready_o && !flush_i;
  assign w_pop  = wb_valid_o && wb_ready_i;
  assign w_new  = make_entry(instr_i[6:0], instr_i[11:7], result_i);

  assign wb_valid_o = w_head_vld;
  assign wb_we_o    = w_head_vld && r_head.we;
  assign wb_rd_o    = w_head_vld ? r_head.rd   : '0;
  assign wb_data_o  = w_head_vld ? r_head.data : '0;

  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush_i) begin
      // Any same-cycle pop has already been consumed by writeback; the push is dropped.
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_head  <= w_new;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_push && !w_pop) begin
            r_tail  <= w_new;
            r_state <= ST_FULL;
          end else if (w_pop && !w_push) begin
            r_head  <= '0;
            r_state <= ST_EMPTY;
          end else if (w_push && w_pop) begin
            r_head  <= w_new;
          end
        end
        ST_FULL: begin
          // ready_o is low here, so only a pop can happen.
          if (w_pop) begin
            r_head  <= r_tail;
            r_tail  <= '0;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_head  <= '0;
          r_tail  <= '0;
        end
      endcase
    end
  end

  fwd_match u_fwd_match1 (
    .i_head_vld (w_head_vld),
    .i_head     (r_head),
    .i_tail_vld (w_tail_vld),
    .i_tail     (r_tail),
    .i_rs       (fwd_rs1_i),
    .o_hit      (fwd_hit1_o),
    .o_data     (fwd_data1_o)
  );

  fwd_match u_fwd_match2 (
    .i_head_vld (w_head_vld),
    .i_head     (r_head),
    .i_tail_vld (w_tail_vld),
    .i_tail     (r_tail),
    .i_rs       (fwd_rs2_i),
    .o_hit      (fwd_hit2_o),
    .o_data     (fwd_data2_o)
  );

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed testbench for alu_wb_stage: linear stimulus, hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
module tb_alu_wb_stage;

  logic        clk_i;
  logic        rsn_i;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [63:0] result_i;
  logic        ready_o;
  logic        flush_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_data_o;
  logic [4:0]  fwd_rs1_i;
  logic [4:0]  fwd_rs2_i;
  logic        fwd_hit1_o;
  logic        fwd_hit2_o;
  logic [63:0] fwd_data1_o;
  logic [63:0] fwd_data2_o;

  int checks = 0;
  int errors = 0;

  alu_wb_stage dut (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .valid_i     (valid_i),
    .instr_i     (instr_i),
    .result_i    (result_i),
    .ready_o     (ready_o),
    .flush_i     (flush_i),
    .wb_valid_o  (wb_valid_o),
    .wb_ready_i  (wb_ready_i),
    .wb_we_o     (wb_we_o),
    .wb_rd_o     (wb_rd_o),
    .wb_data_o   (wb_data_o),
    .fwd_rs1_i   (fwd_rs1_i),
    .fwd_rs2_i   (fwd_rs2_i),
    .fwd_hit1_o  (fwd_hit1_o),
    .fwd_hit2_o  (fwd_hit2_o),
    .fwd_data1_o (fwd_data1_o),
    .fwd_data2_o (fwd_data2_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd);
    return {20'h0, rd, opc};
  endfunction

  task automatic drive(input logic v, input logic [6:0] opc, input logic [4:0] rd,
                       input logic [63:0] res);
    valid_i  = v;
    instr_i  = mk(opc, rd);
    result_i = res;
  endtask

  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;

  initial begin
    rsn_i = 1'b1; valid_i = 1'b0; instr_i = '0; result_i = '0;
    flush_i = 1'b0; wb_ready_i = 1'b0; fwd_rs1_i = 5'd0; fwd_rs2_i = 5'd0;

    // Reset window
    tick(); tick();
    chk("rst_ready", ready_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_hit1", fwd_hit1_o, 0);
    chk("rst_hit2", fwd_hit2_o, 0);
    rsn_i = 1'b0;
    #1;
    chk("post_rst_ready", ready_o, 1);
    chk("post_rst_wb_valid", wb_valid_o, 0);

    // add x5 = 0x10, presented the next cycle
    tick();
    drive(1, OPR, 5'd5, 64'h10);
    tick();
    drive(0, OPR, 5'd0, 64'h0);
    chk("add_wb_valid", wb_valid_o, 1);
    chk("add_wb_rd", wb_rd_o, 5);
    chk("add_wb_we", wb_we_o, 1);
    chk("add_wb_data", wb_data_o, 64'h10);
    chk("add_ready", ready_o, 1);
    wb_ready_i = 1'b1;
    tick();
    chk("add_retired_valid", wb_valid_o, 0);
    chk("empty_data_zero", wb_data_o, 0);

    // Backpressure: A then B held, then retire in order
    wb_ready_i = 1'b0;
    drive(1, OPR, 5'd1, 64'hA);
    tick();
    chk("ab_ready_after_a", ready_o, 1);
    drive(1, OPI, 5'd2, 64'hB);
    tick();
    drive(0, OPR, 5'd0, 64'h0);
    chk("ab_ready_full", ready_o, 0);
    chk("ab_head_rd", wb_rd_o, 1);
    tick();
    chk("ab_hold_data", wb_data_o, 64'hA);
    chk("ab_hold_valid", wb_valid_o, 1);
    wb_ready_i = 1'b1;
    tick();
    chk("ab_b_rd", wb_rd_o, 2);
    chk("ab_b_data", wb_data_o, 64'hB);
    chk("ab_ready_one", ready_o, 1);
    tick();
    chk("ab_empty", wb_valid_o, 0);

    // Forwarding with two writes to x3: the tail wins
    wb_ready_i = 1'b0;
    drive(1, OPR, 5'd3, 64'h1);
    tick();
    drive(1, OPR, 5'd3, 64'h2);
    tick();
    drive(0, OPR, 5'd0, 64'h0);
    fwd_rs1_i = 5'd3; fwd_rs2_i = 5'd0;
    #1;
    chk("fwd_hit1", fwd_hit1_o, 1);
    chk("fwd_data1_tail", fwd_data1_o, 64'h2);
    chk("fwd_hit2_x0", fwd_hit2_o, 0);
    chk("fwd_data2_x0", fwd_data2_o, 0);
    fwd_rs2_i = 5'd7;
    #1;
    chk("fwd_miss_hit", fwd_hit2_o, 0);
    chk("fwd_miss_data", fwd_data2_o, 0);

    // Flush from FULL with a concurrent push
    flush_i = 1'b1;
    drive(1, OPR, 5'd9, 64'h99);
    tick();
    flush_i = 1'b0;
    drive(0, OPR, 5'd0, 64'h0);
    chk("flush_wb_valid", wb_valid_o, 0);
    chk("flush_ready", ready_o, 1);
    chk("flush_hit1", fwd_hit1_o, 0);
    tick();
    chk("flush_never_appears", wb_valid_o, 0);

    // ONE with simultaneous push and pop
    drive(1, OPR, 5'd4, 64'h40);
    tick();
    chk("pp_one_rd", wb_rd_o, 4);
    drive(1, OPR, 5'd6, 64'h60);
    wb_ready_i = 1'b1;
    tick();
    drive(0, OPR, 5'd0, 64'h0);
    wb_ready_i = 1'b0;
    chk("pp_valid", wb_valid_o, 1);
    chk("pp_rd", wb_rd_o, 6);
    chk("pp_data", wb_data_o, 64'h60);
    chk("pp_ready_one", ready_o, 1);
    fwd_rs1_i = 5'd6;
    #1;
    chk("pp_head_fwd", fwd_data1_o, 64'h60);
    wb_ready_i = 1'b1;
    tick();
    chk("pp_empty", wb_valid_o, 0);

    // Non-writing entries: addi x0 and a load
    wb_ready_i = 1'b0;
    drive(1, OPI, 5'd0, 64'h55);
    tick();
    chk("x0_valid", wb_valid_o, 1);
    chk("x0_we", wb_we_o, 0);
    drive(1, OPL, 5'd8, 64'h88);
    tick();
    drive(0, OPR, 5'd0, 64'h0);
    fwd_rs1_i = 5'd0; fwd_rs2_i = 5'd8;
    #1;
    chk("x0_no_fwd", fwd_hit1_o, 0);
    chk("ld_no_fwd", fwd_hit2_o, 0);
    chk("ld_no_fwd_data", fwd_data2_o, 0);
    wb_ready_i = 1'b1;
    tick();
    chk("ld_rd", wb_rd_o, 8);
    chk("ld_we", wb_we_o, 0);
    chk("ld_data", wb_data_o, 64'h88);
    tick();
    chk("ld_retired", wb_valid_o, 0);

    // Reset asserted while an entry is held
    wb_ready_i = 1'b0;
    drive(1, OPR, 5'd10, 64'hAA);
    tick();
    drive(0, OPR, 5'd0, 64'h0);
    fwd_rs1_i = 5'd10;
    #1;
    chk("mid_pre_hit", fwd_hit1_o, 1);
    rsn_i = 1'b1;
    #1;
    chk("mid_rst_valid", wb_valid_o, 0);
    chk("mid_rst_ready", ready_o, 0);
    chk("mid_rst_hit", fwd_hit1_o, 0);
    tick();
    rsn_i = 1'b0;
    wb_ready_i = 1'b1;
    #1;
    chk("mid_rel_ready", ready_o, 1);
    tick();
    chk("mid_discarded", wb_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have port clk_i, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rsn_i, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port valid_i, input, 1, int_alu result for instr_i is valid this cycle.
REQ-004 SHALL have port instr_i, input, 32, instruction whose result is presented.
REQ-005 SHALL have port result_i, input, 64, int_alu data_out_o.
REQ-006 SHALL have port ready_o, output, 1, stage accepts an entry this cycle.
REQ-007 SHALL have port flush_i, input, 1, discard all held and incoming entries.
REQ-008 SHALL have port wb_valid_o, output, 1, head entry presented to writeback.
REQ-009 SHALL have port wb_ready_i, input, 1, writeback consumes head this cycle.
REQ-010 SHALL have port wb_we_o, output, 1, head entry writes the register file.
REQ-011 SHALL have port wb_rd_o, output, 5, head destination register.
REQ-012 SHALL have port wb_data_o, output, 64, head result.
REQ-013 SHALL have ports fwd_rs1_i and fwd_rs2_i, input, 5 each, source registers queried by issue.
REQ-014 SHALL have ports fwd_hit1_o and fwd_hit2_o, output, 1 each, held entry matches query.
REQ-015 SHALL have ports fwd_data1_o and fwd_data2_o, output, 64 each, forwarded value.

Function
REQ-016 SHALL implement a 2-entry in-order skid buffer, states EMPTY, ONE, FULL.
REQ-017 SHALL drive ready_o = (state != FULL) from registered state only, with no combinational path from wb_ready_i.
REQ-018 SHALL accept an entry when valid_i && ready_o && !flush_i; it captures rd = instr_i[11:7], result_i, and we.
REQ-019 SHALL set we = 1 only for opcode instr_i[6:0] in {0110011, 0010011} and rd != 0; otherwise we = 0, but the entry is still retired.
REQ-020 SHALL pop the head when wb_valid_o && wb_ready_i.
REQ-021 SHALL make transitions: EMPTY+push -> ONE; ONE+push-pop -> FULL; ONE+pop-push -> EMPTY; ONE+push+pop -> ONE, new entry becomes head; FULL+pop -> ONE, tail becomes head; otherwise hold.
REQ-022 SHALL drive wb_valid_o = (state != EMPTY), with wb_we_o, wb_rd_o and wb_data_o taken from the head; these SHALL be 0 when EMPTY.
REQ-023 SHALL give a latency of 1 cycle: an entry accepted in cycle N is presented in cycle N+1 when the stage was EMPTY.
REQ-024 SHALL make flush_i dominate: next state EMPTY, the same-cycle push is ignored, and the same-cycle pop still completes.
REQ-025 SHALL make forwarding combinational over held entries with we = 1 and rd == query; the younger (tail) entry wins over the head; a query of rd 0 SHALL never hit; the data output SHALL be 0 on a miss.
REQ-026 SHALL hold entries unchanged while wb_ready_i = 0, with no data loss and no duplication.

Reset
REQ-027 SHALL asynchronously force state EMPTY and clear both entries while rsn_i = 1.
REQ-028 SHALL hold ready_o = 0, wb_valid_o = 0 and all fwd_hit outputs = 0 during reset; ready_o SHALL be 1 in the first cycle after release.
REQ-029 SHALL discard entries held at reset assertion mid-operation; they SHALL never be presented.

Structure
REQ-030 SHALL take OP_REG = 7'b0110011, OP_IMM = 7'b0010011, XLEN = 64 and the state encoding from the shared package vi_pkg.
REQ-031 SHALL instantiate sub-module fwd_match twice, once per query port: an entry rd/we compare with tail-priority select.

Verification
REQ-032 SHALL cover: reset release, then valid_i=1, add x5 with result 0x10 -> next cycle wb_valid_o=1, wb_rd_o=5, wb_we_o=1, wb_data_o=0x10.
REQ-033 SHALL cover: wb_ready_i=0, push A (x1=0xA) and B (x2=0xB) -> ready_o=0 after the second push; then wb_ready_i=1 -> A then B retire on consecutive cycles.
REQ-034 SHALL cover: state FULL with x3=1 (head) and x3=2 (tail), fwd_rs1_i=3 -> fwd_hit1_o=1, fwd_data1_o=2; fwd_rs2_i=0 -> fwd_hit2_o=0.
REQ-035 SHALL cover: state ONE with push and pop in the same cycle -> state stays ONE and the new entry is presented the next cycle.
REQ-036 SHALL cover: state FULL, flush_i=1 with valid_i=1 -> the next cycle wb_valid_o=0 and ready_o=1; the flushed entry never appears.
REQ-037 SHALL cover: addi x0, or opcode 0000011 -> entry retires with wb_we_o=0 and never forwards.
